// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: divider FSM encoding and datapath width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arith_pkg;

    // Width shared with the 16x16 multiplier; the divider dividend is twice this.
    localparam int DIV_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and conditionally subtract.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports:
//   r       partial remainder (W+1 bits), always < divisor on entry
//   q       shifting register: unconsumed dividend bits on top, quotient bits filling in from the bottom
//   divisor W-bit unsigned divisor
//   r_nxt   partial remainder after this step
//   q_nxt   q shifted left by one with the new quotient bit in the LSB
module div_step #(
    parameter int W = 16
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_nxt,
    output logic [W-1:0] q_nxt
);

    logic [W:0] t;
    logic [W:0] d_ext;
    logic       ge;

    // r < divisor between steps, so its MSB is always zero and only the low W bits shift up.
    logic unused_r_msb;
    assign unused_r_msb = r[W];

    // t can reach 2*divisor-1, hence the extra bit.
    assign t     = {r[W-1:0], q[W-1]};
    assign d_ext = {1'b0, divisor};
    assign ge    = (t >= d_ext);

    assign r_nxt = ge ? (t - d_ext) : t;
    assign q_nxt = {q[W-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Latency: out_valid in cycle W+1 after accept; divide-by-zero or overflow results in cycle 1.
// Backpressure: result held in DONE indefinitely until out_ready; in_ready low outside IDLE.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      request handshake; dividend and divisor sampled on the accept edge only
//   out_valid/out_ready    result handshake; quotient, remainder, div_by_zero, overflow valid with out_valid
module seq_divider
    import arith_pkg::*;
#(
    parameter int W = DIV_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int              CW       = $clog2(W);
    localparam logic [CW-1:0]   CNT_LAST = CW'(W - 1);

    div_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W:0]    r_q;
    logic [W-1:0]  q_q;
    logic [W-1:0]  dvs_q;
    logic          dbz_q, ovf_q;

    logic [W:0]    r_nxt;
    logic [W-1:0]  q_nxt;

    logic [W-1:0]  dvd_hi, dvd_lo;
    logic          accept;
    logic          is_zero;
    logic          is_ovf;

    assign dvd_hi  = dividend[2*W-1:W];
    assign dvd_lo  = dividend[W-1:0];
    assign accept  = in_valid && in_ready;
    assign is_zero = (divisor == '0);
    // The quotient fits in W bits exactly when the upper half is below the divisor.
    assign is_ovf  = !is_zero && (dvd_hi >= divisor);

    div_step #(.W(W)) u_step (
        .r       (r_q),
        .q       (q_q),
        .divisor (dvs_q),
        .r_nxt   (r_nxt),
        .q_nxt   (q_nxt)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = (is_zero || is_ovf) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            r_q   <= '0;
            q_q   <= '0;
            dvs_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        dvs_q <= divisor;
                        if (is_zero) begin
                            q_q   <= '1;
                            r_q   <= {1'b0, dvd_lo};
                            dbz_q <= 1'b1;
                            ovf_q <= 1'b0;
                        end else if (is_ovf) begin
                            q_q   <= '1;
                            r_q   <= '0;
                            dbz_q <= 1'b0;
                            ovf_q <= 1'b1;
                        end else begin
                            r_q   <= {1'b0, dvd_hi};
                            q_q   <= dvd_lo;
                            cnt_q <= CNT_LAST;
                            dbz_q <= 1'b0;
                            ovf_q <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= r_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q - 1'b1;
                end
                default: begin
                    // DONE: hold everything stable under backpressure.
                end
            endcase
        end
    end

    // Result fields come straight from the working registers; they only mean anything with out_valid.
    assign quotient    = q_q;
    assign remainder   = r_q[W-1:0];
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*W-1:0] dividend;
    logic [W-1:0]   divisor;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;
    logic           overflow;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division; result packed as {quotient, remainder, div_by_zero, overflow}.
    function automatic logic [2*W+1:0] model(input logic [2*W-1:0] n, input logic [W-1:0] d);
        longint unsigned nn, dd, qq, rr;
        logic [W-1:0] qlo, rlo, nlo;
        nn = longint'(n);
        dd = longint'(d);
        nlo = n[W-1:0];
        if (dd == 0) return {{W{1'b1}}, nlo, 1'b1, 1'b0};
        qq = nn / dd;
        rr = nn % dd;
        if (qq > 64'hFFFF) return {{W{1'b1}}, {W{1'b0}}, 1'b0, 1'b1};
        qlo = W'(qq);
        rlo = W'(rr);
        return {qlo, rlo, 1'b0, 1'b0};
    endfunction

    // Drives one request with out_ready=1; returns captured result and the cycle out_valid first rose.
    task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                         output logic [2*W+1:0] res, output int cyc);
        in_valid  = 1'b1;
        dividend  = dvd;
        divisor   = dvs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;      // later input changes must not matter
        divisor  = W'($urandom);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: out_valid never rose for %0d / %0d", dvd, dvs);
            cyc = -1;
        end
        res = {quotient, remainder, div_by_zero, overflow};
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 34'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
    endtask

    task automatic test_exact();
        logic [2*W+1:0] res; int cyc;
        do_op(32'd670592745, 16'd12345, res, cyc);
        n_cmp++;
        if (res !== {16'd54321, 16'd0, 2'b00}) begin
            n_err++; $display("FAIL exact_result: got %h want %h", res, {16'd54321, 16'd0, 2'b00});
        end
        n_cmp++;
        if (cyc !== 17) begin
            n_err++; $display("FAIL exact_latency: got cycle %0d want 17", cyc);
        end
    endtask

    task automatic test_basic();
        logic [2*W+1:0] res; int cyc;
        do_op(32'd100, 16'd7, res, cyc);
        n_cmp++;
        if (res !== {16'd14, 16'd2, 2'b00}) begin
            n_err++; $display("FAIL basic_100_7: got %h want %h", res, {16'd14, 16'd2, 2'b00});
        end
        do_op(32'd0, 16'd1, res, cyc);
        n_cmp++;
        if (res !== 34'd0) begin
            n_err++; $display("FAIL basic_0_1: got %h want 0", res);
        end
    endtask

    task automatic test_max();
        logic [2*W+1:0] res; int cyc;
        do_op(32'hFFFE0001, 16'hFFFF, res, cyc);
        n_cmp++;
        if (res !== {16'hFFFF, 16'h0000, 2'b00}) begin
            n_err++; $display("FAIL max_quotient: got %h want %h", res, {16'hFFFF, 16'h0000, 2'b00});
        end
    endtask

    task automatic test_special();
        logic [2*W+1:0] res; int cyc;
        do_op(32'h12345678, 16'h0000, res, cyc);
        n_cmp++;
        if (res !== {16'hFFFF, 16'h5678, 2'b10}) begin
            n_err++; $display("FAIL div_zero_result: got %h want %h", res, {16'hFFFF, 16'h5678, 2'b10});
        end
        n_cmp++;
        if (cyc !== 1) begin
            n_err++; $display("FAIL div_zero_latency: got cycle %0d want 1", cyc);
        end
        do_op(32'h00010000, 16'h0001, res, cyc);
        n_cmp++;
        if (res !== {16'hFFFF, 16'h0000, 2'b01}) begin
            n_err++; $display("FAIL overflow_result: got %h want %h", res, {16'hFFFF, 16'h0000, 2'b01});
        end
        n_cmp++;
        if (cyc !== 1) begin
            n_err++; $display("FAIL overflow_latency: got cycle %0d want 1", cyc);
        end
    endtask

    task automatic test_backpressure();
        logic [2*W+1:0] res, held; int cyc; int bad;
        out_ready = 1'b0;
        in_valid = 1'b1; dividend = 32'd1000; divisor = 16'd33;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
        held = {quotient, remainder, div_by_zero, overflow};
        n_cmp++;
        if (!out_valid || held !== model(32'd1000, 16'd33)) begin
            n_err++; $display("FAIL bp_result: vld=%b got %h want %h", out_valid, held, model(32'd1000, 16'd33));
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; dividend = $urandom; divisor = W'($urandom);
            @(posedge clk); #1;
            if (!out_valid || in_ready || {quotient, remainder, div_by_zero, overflow} !== held) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_err++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL bp_release: got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
        end
        do_op(32'd99999, 16'd77, res, cyc);
        n_cmp++;
        if (res !== model(32'd99999, 16'd77)) begin
            n_err++; $display("FAIL bp_next_req: got %h want %h", res, model(32'd99999, 16'd77));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [2*W+1:0] res; int cyc; int seen;
        out_ready = 1'b1;
        in_valid = 1'b1; dividend = 32'd100; divisor = 16'd7;
        @(posedge clk); #1;               // cycle 1
        in_valid = 1'b0;
        repeat (7) @(posedge clk);        // cycle 8
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({in_ready, out_valid, quotient, remainder, div_by_zero, overflow} !== {1'b1, 1'b0, 34'b0}) begin
            n_err++;
            $display("FAIL rst_mid_run: got rdy=%b vld=%b q=%h r=%h dbz=%b ovf=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero, overflow);
        end
        seen = 0;
        repeat (25) begin @(posedge clk); #1; if (out_valid) seen++; end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL rst_no_result: out_valid high %0d cycles, want 0", seen);
        end
        do_op(32'd100, 16'd7, res, cyc);
        n_cmp++;
        if (res !== {16'd14, 16'd2, 2'b00}) begin
            n_err++; $display("FAIL rst_recover: got %h want %h", res, {16'd14, 16'd2, 2'b00});
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W+1:0] res; int cyc;
        do_op(32'd5000000, 16'd321, res, cyc);
        n_cmp++;
        if (in_ready !== 1'b1 || res !== model(32'd5000000, 16'd321)) begin
            n_err++; $display("FAIL b2b_first: rdy=%b got %h want %h", in_ready, res, model(32'd5000000, 16'd321));
        end
        do_op(32'd65535, 16'd2, res, cyc);
        n_cmp++;
        if (res !== model(32'd65535, 16'd2)) begin
            n_err++; $display("FAIL b2b_second: got %h want %h", res, model(32'd65535, 16'd2));
        end
    endtask

    task automatic test_random();
        logic [2*W+1:0] res, exp; int cyc;
        logic [W-1:0] a, b, d;
        logic [2*W-1:0] p, n;
        // Inverse of the multiplier: (a*b)/a == b, remainder 0.
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom_range(1, 65535));
            b = W'($urandom);
            p = {16'b0, a} * {16'b0, b};
            do_op(p, a, res, cyc);
            n_cmp++;
            if (res !== {b, 16'd0, 2'b00} || cyc !== 17) begin
                n_err++; $display("FAIL mult_inverse: %0d/%0d got %h cyc %0d want %h cyc 17", p, a, res, cyc, {b, 16'd0, 2'b00});
            end
        end
        // General operands, biased towards small divisors, zero and overflow.
        for (int i = 0; i < 30; i++) begin
            n = $urandom;
            case (i % 5)
                0: d = 16'd0;
                1: d = W'($urandom_range(1, 15));
                2: begin d = W'($urandom_range(1, 65535)); n = {W'($urandom_range(0, 32'(d) - 1)), W'($urandom)}; end
                default: d = W'($urandom);
            endcase
            exp = model(n, d);
            do_op(n, d, res, cyc);
            n_cmp++;
            if (res !== exp) begin
                n_err++; $display("FAIL random_div: %0d/%0d got %h want %h", n, d, res, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact();
        test_basic();
        test_max();
        test_special();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
